ocd_cmd_engine: RTL and testbench

//  Debug front end sitting upstream of the MCU top: consumes bytes from a UART receiver, parses fixed
//  11-byte command frames, and drives the MCU's ocd_* memory/register ports, start/start_address and a

---
 rtl/ocd_cmd_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_ocd_cmd_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocd_cmd_engine.sv
// ---------------------------------------------------------------------------
// ocd_cmd_engine
//   Debug command front end for the MCU. Receives 11-byte command frames from
//   a UART receiver, executes memory/register/run/reset commands on the MCU's
//   ocd_* ports and returns a 6-byte reply through a UART transmitter.
//
//   Frame : 5A CMD A[31:24..7:0] D[31:24..7:0] CHK   (CHK = XOR of CMD..D[7:0])
//   Reply : A5 STATUS R[31:24..7:0]
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   sync_reset            synchronous reset, same effect as reset_n
//   rx_data/rx_valid      received byte + one-cycle strobe
//   tx_data/tx_start      byte to send + one-cycle launch strobe
//   tx_active             transmitter busy
//   ocd_read_enable       one-cycle memory read request
//   ocd_write_enable      one-cycle memory write request
//   ocd_rw_addr           memory word address
//   ocd_write_word        memory write data
//   ocd_mem_enable_out    read data valid strobe
//   ocd_mem_word_out      read data
//   ocd_reg_read_addr     register address of last frame
//   ocd_reg_we            one-cycle register write strobe
//   ocd_reg_write_addr    register write address
//   ocd_reg_write_data    register write data
//   start/start_address   one-cycle run strobe + entry address
//   processor_paused      core halted; run only honoured when high
//   cpu_sync_reset        RST_CYCLES-wide reset pulse toward the MCU
// ---------------------------------------------------------------------------
`ifndef XLEN
  `define XLEN 32
`endif
`ifndef MEM_ADDR_BITS
  `define MEM_ADDR_BITS 16
`endif
`ifndef REG_ADDR_BITS
  `define REG_ADDR_BITS 5
`endif
`ifndef PC_BITWIDTH
  `define PC_BITWIDTH 32
`endif

module ocd_cmd_engine #(
  parameter int BYTE_TIMEOUT = 1000000,
  parameter int RD_WAIT_MAX  = 255,
  parameter int RST_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sync_reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [7:0]                tx_data,
  output logic                      tx_start,
  input  logic                      tx_active,
  output logic                      ocd_read_enable,
  output logic                      ocd_write_enable,
  output logic [`MEM_ADDR_BITS-1:0] ocd_rw_addr,
  output logic [`XLEN-1:0]          ocd_write_word,
  input  logic                      ocd_mem_enable_out,
  input  logic [`XLEN-1:0]          ocd_mem_word_out,
  output logic [`REG_ADDR_BITS-1:0] ocd_reg_read_addr,
  output logic                      ocd_reg_we,
  output logic [`REG_ADDR_BITS-1:0] ocd_reg_write_addr,
  output logic [`XLEN-1:0]          ocd_reg_write_data,
  output logic                      start,
  output logic [`PC_BITWIDTH-1:0]   start_address,
  input  logic                      processor_paused,
  output logic                      cpu_sync_reset
);

  localparam int XW  = `XLEN;
  localparam int MAW = `MEM_ADDR_BITS;
  localparam int RAW = `REG_ADDR_BITS;
  localparam int PCW = `PC_BITWIDTH;
  localparam int TW  = $clog2(BYTE_TIMEOUT + 1);
  localparam int RW  = $clog2(RD_WAIT_MAX + 1);
  localparam int CW  = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX      = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT_RD = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  // Frame body after the header; CHK is only folded into chk_acc, never stored.
  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } frame_t;

  // All state lives in one struct so both resets clear everything in one line.
  typedef struct packed {
    state_t          state;
    logic [71:0]     frm;
    logic [3:0]      rx_cnt;
    logic [7:0]      chk_acc;
    logic [TW-1:0]   to_cnt;
    logic [RW-1:0]   rd_cnt;
    logic [CW-1:0]   rst_cnt;
    logic [47:0]     reply;
    logic [2:0]      tx_cnt;
    logic            tx_skip;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            rd_en;
    logic            wr_en;
    logic            reg_we;
    logic            start;
    logic            cpu_rst;
    logic [MAW-1:0]  rw_addr;
    logic [XW-1:0]   wr_word;
    logic [RAW-1:0]  reg_addr;
    logic [XW-1:0]   reg_wdata;
    logic [PCW-1:0]  start_addr;
  } regs_t;

  regs_t      s;
  frame_t     f;
  logic       chk_ok;
  logic [7:0] exec_status;

  assign f      = frame_t'(s.frm);
  // XOR over CMD..CHK is zero exactly when CHK matches.
  assign chk_ok = (s.chk_acc == 8'h00);

  always_comb begin
    exec_status = 8'hE0;
    if (!chk_ok) exec_status = 8'hEE;
    else begin
      case (f.cmd)
        8'h01, 8'h02, 8'h03, 8'h05: exec_status = 8'h00;
        8'h04:   exec_status = processor_paused ? 8'h00 : 8'hE1;
        default: exec_status = 8'hE0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s <= '0;
    else if (sync_reset) s <= '0;
    else begin
      s.tx_start <= 1'b0;
      s.rd_en    <= 1'b0;
      s.wr_en    <= 1'b0;
      s.reg_we   <= 1'b0;
      s.start    <= 1'b0;

      // CPU reset pulse runs on its own so the reply can overlap it.
      if (s.rst_cnt != '0) s.rst_cnt <= s.rst_cnt - 1'b1;
      else                 s.cpu_rst <= 1'b0;

      case (s.state)
        S_IDLE: begin
          if (rx_valid && rx_data == 8'h5A) begin
            s.state   <= S_RX;
            s.rx_cnt  <= '0;
            s.chk_acc <= '0;
            s.to_cnt  <= TW'(BYTE_TIMEOUT - 1);
          end
        end

        S_RX: begin
          if (rx_valid) begin
            // Byte 10 is CHK: it only feeds the running XOR.
            if (s.rx_cnt != 4'd9) s.frm <= {s.frm[63:0], rx_data};
            s.chk_acc <= s.chk_acc ^ rx_data;
            s.rx_cnt  <= s.rx_cnt + 4'd1;
            s.to_cnt  <= TW'(BYTE_TIMEOUT - 1);
            if (s.rx_cnt == 4'd9) s.state <= S_EXEC;
          end else if (s.to_cnt == '0) begin
            s.state <= S_IDLE;
          end else begin
            s.to_cnt <= s.to_cnt - 1'b1;
          end
        end

        S_EXEC: begin
          s.rw_addr    <= f.addr[MAW-1:0];
          s.wr_word    <= XW'(f.data);
          s.reg_addr   <= f.addr[RAW-1:0];
          s.reg_wdata  <= XW'(f.data);
          s.start_addr <= f.addr[PCW-1:0];
          s.reply      <= {8'hA5, exec_status, f.data};
          s.tx_cnt     <= '0;
          s.tx_skip    <= 1'b0;
          s.state      <= S_SEND;
          if (chk_ok) begin
            case (f.cmd)
              8'h01: s.wr_en  <= 1'b1;
              8'h02: begin
                s.rd_en  <= 1'b1;
                s.rd_cnt <= '0;
                s.state  <= S_WAIT_RD;
              end
              8'h03: s.reg_we <= 1'b1;
              8'h04: s.start  <= processor_paused;
              8'h05: begin
                s.cpu_rst <= 1'b1;
                s.rst_cnt <= CW'(RST_CYCLES - 1);
              end
              default: ;
            endcase
          end
        end

        S_WAIT_RD: begin
          // First cycle here is the read-request cycle, so a same-cycle
          // strobe from memory is captured too.
          if (ocd_mem_enable_out) begin
            s.reply <= {8'hA5, 8'h00, 32'(ocd_mem_word_out)};
            s.state <= S_SEND;
          end else if (s.rd_cnt == RW'(RD_WAIT_MAX - 1)) begin
            s.reply <= {8'hA5, 8'hEF, 32'h0};
            s.state <= S_SEND;
          end else begin
            s.rd_cnt <= s.rd_cnt + 1'b1;
          end
        end

        S_SEND: begin
          // tx_active only rises the cycle after tx_start, so the cycle right
          // after a launch must not be trusted.
          if (s.tx_skip) s.tx_skip <= 1'b0;
          else if (!tx_active) begin
            s.tx_start <= 1'b1;
            s.tx_data  <= s.reply[47:40];
            s.reply    <= {s.reply[39:0], 8'h00};
            s.tx_skip  <= 1'b1;
            if (s.tx_cnt == 3'd5) s.state <= S_IDLE;
            else                  s.tx_cnt <= s.tx_cnt + 3'd1;
          end
        end

        default: s.state <= S_IDLE;
      endcase
    end
  end

  assign tx_data            = s.tx_data;
  assign tx_start           = s.tx_start;
  assign ocd_read_enable    = s.rd_en;
  assign ocd_write_enable   = s.wr_en;
  assign ocd_rw_addr        = s.rw_addr;
  assign ocd_write_word     = s.wr_word;
  assign ocd_reg_read_addr  = s.reg_addr;
  assign ocd_reg_we         = s.reg_we;
  assign ocd_reg_write_addr = s.reg_addr;
  assign ocd_reg_write_data = s.reg_wdata;
  assign start              = s.start;
  assign start_address      = s.start_addr;
  assign cpu_sync_reset     = s.cpu_rst;

endmodule

// File: tb/tb_ocd_cmd_engine.sv
// Scoreboard bench for ocd_cmd_engine: the driver pushes expected reply bytes
// and side-effect events; monitors pop and compare as the DUT produces them.
module tb_ocd_cmd_engine;
  localparam int BT  = 200;
  localparam int RDM = 40;
  localparam int RC  = 4;

  logic        clk = 1'b0, reset_n = 1'b0, sync_reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_active = 1'b0;
  logic        ocd_read_enable, ocd_write_enable;
  logic [15:0] ocd_rw_addr;
  logic [31:0] ocd_write_word;
  logic        ocd_mem_enable_out = 1'b0;
  logic [31:0] ocd_mem_word_out = 32'hBAD0BAD0;
  logic [4:0]  ocd_reg_read_addr, ocd_reg_write_addr;
  logic        ocd_reg_we;
  logic [31:0] ocd_reg_write_data;
  logic        start;
  logic [31:0] start_address;
  logic        processor_paused = 1'b0;
  logic        cpu_sync_reset;

  always #5 clk = ~clk;

  ocd_cmd_engine #(.BYTE_TIMEOUT(BT), .RD_WAIT_MAX(RDM), .RST_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_active(tx_active),
    .ocd_read_enable(ocd_read_enable), .ocd_write_enable(ocd_write_enable),
    .ocd_rw_addr(ocd_rw_addr), .ocd_write_word(ocd_write_word),
    .ocd_mem_enable_out(ocd_mem_enable_out), .ocd_mem_word_out(ocd_mem_word_out),
    .ocd_reg_read_addr(ocd_reg_read_addr), .ocd_reg_we(ocd_reg_we),
    .ocd_reg_write_addr(ocd_reg_write_addr), .ocd_reg_write_data(ocd_reg_write_data),
    .start(start), .start_address(start_address),
    .processor_paused(processor_paused), .cpu_sync_reset(cpu_sync_reset)
  );

  typedef struct {
    int          kind;   // 1 wr, 2 rd, 3 reg we, 4 start, 5 cpu reset
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         ev_q[$];
  logic [7:0]  exp_q[$];
  int          n_chk = 0, n_fail = 0, tx_seen = 0;
  int          rd_lat = 0;
  bit          rd_respond = 1'b1;
  logic [31:0] rd_word = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d;
    ev_q.push_back(e);
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_tx"}, {56'h0, tx_data}, 64'h0);
    check({tag, "_strobes"}, {59'h0, tx_start, ocd_read_enable, ocd_write_enable,
                              ocd_reg_we, start}, 64'h0);
    check({tag, "_mem"}, {ocd_rw_addr, ocd_write_word}, 64'h0);
    check({tag, "_reg"}, {ocd_reg_read_addr, ocd_reg_write_addr, ocd_reg_write_data}, 64'h0);
    check({tag, "_run"}, {cpu_sync_reset, start_address}, 64'h0);
  endtask

  // External UART transmitter: busy from the cycle after tx_start.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      @(posedge clk); #1 tx_active = 1'b1;
      repeat ($urandom_range(6, 1)) @(posedge clk);
      #1 tx_active = 1'b0;
    end
  end

  // Memory model: answers a read rd_lat cycles after the request (0 = same cycle).
  initial forever begin
    @(negedge clk);
    if (ocd_read_enable) begin
      repeat (rd_lat) @(negedge clk);
      if (rd_respond) begin
        ocd_mem_enable_out = 1'b1;
        ocd_mem_word_out   = rd_word;
        @(negedge clk);
        ocd_mem_enable_out = 1'b0;
        ocd_mem_word_out   = $urandom;
      end
    end
  end

  // Monitor: reply bytes, side-effect strobes, cpu reset width.
  initial begin : mon
    logic cprev;
    int   width, kind;
    ev_t  e;
    cprev = 1'b0; width = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin cprev = 1'b0; width = 0; continue; end
      if (tx_start) begin
        tx_seen++;
        check("tx_while_busy", {63'h0, tx_active}, 64'h0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got byte %0h expected none", tx_data);
        end else check("tx_byte", {56'h0, tx_data}, {56'h0, exp_q.pop_front()});
      end
      if (ocd_write_enable | ocd_read_enable | ocd_reg_we | start) begin
        kind = ocd_write_enable ? 1 : ocd_read_enable ? 2 : ocd_reg_we ? 3 : 4;
        if (ev_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL strobe_unexpected: got kind %0d expected none", kind);
        end else begin
          e = ev_q.pop_front();
          check("strobe_kind", 64'(kind), 64'(e.kind));
          case (kind)
            1: begin
              check("wr_addr", {48'h0, ocd_rw_addr}, {48'h0, e.a[15:0]});
              check("wr_word", {32'h0, ocd_write_word}, {32'h0, e.d});
            end
            2: check("rd_addr", {48'h0, ocd_rw_addr}, {48'h0, e.a[15:0]});
            3: begin
              check("reg_waddr", {59'h0, ocd_reg_write_addr}, {59'h0, e.a[4:0]});
              check("reg_raddr", {59'h0, ocd_reg_read_addr}, {59'h0, e.a[4:0]});
              check("reg_wdata", {32'h0, ocd_reg_write_data}, {32'h0, e.d});
            end
            default: check("start_addr", {32'h0, start_address}, {32'h0, e.a});
          endcase
        end
      end
      if (cpu_sync_reset && !cprev) begin
        if (ev_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cpu_rst_unexpected: got pulse expected none");
        end else begin
          e = ev_q.pop_front();
          check("cpu_rst_kind", 64'd5, 64'(e.kind));
        end
      end
      if (cpu_sync_reset) width++;
      else if (cprev) begin
        check("rst_width", 64'(width), 64'(RC));
        width = 0;
      end
      cprev = cpu_sync_reset;
    end
  end

  // Driver helpers: all start and end just after a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_noise(input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      if (v == 8'h5A) v = 8'hA5;
      send_byte(v, $urandom_range(2, 0));
    end
  endtask

  task automatic wait_reply();
    int n = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("reply_timeout", {63'h0, n >= 3000}, 64'h0);
    if (n >= 3000) begin exp_q.delete(); ev_q.delete(); end
    repeat (10) @(negedge clk);
  endtask

  // Reference model: status/reply/side effect straight from the command rules.
  task automatic frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                       input bit corrupt, input int gmax, input int gfix, input bit nowait);
    logic [7:0]  b [11];
    logic [7:0]  st;
    logic [31:0] r;
    b[0] = 8'h5A; b[1] = cmd;
    for (int i = 0; i < 4; i++) begin
      b[2 + i] = a[31 - 8*i -: 8];
      b[6 + i] = d[31 - 8*i -: 8];
    end
    b[10] = 8'h00;
    for (int i = 1; i < 10; i++) b[10] = b[10] ^ b[i];
    if (corrupt) b[10] = b[10] ^ 8'(1 << $urandom_range(7, 0));
    r = d;
    if (corrupt) st = 8'hEE;
    else begin
      case (cmd)
        8'h01: begin st = 8'h00; push_ev(1, a, d); end
        8'h02: begin
          push_ev(2, a, d);
          if (rd_respond && rd_lat < RDM) begin st = 8'h00; r = rd_word; end
          else begin st = 8'hEF; r = 32'h0; end
        end
        8'h03: begin st = 8'h00; push_ev(3, a, d); end
        8'h04: if (processor_paused) begin st = 8'h00; push_ev(4, a, d); end
               else st = 8'hE1;
        8'h05: begin st = 8'h00; push_ev(5, a, d); end
        default: st = 8'hE0;
      endcase
    end
    exp_q.push_back(8'hA5);
    exp_q.push_back(st);
    for (int i = 0; i < 4; i++) exp_q.push_back(r[31 - 8*i -: 8]);
    for (int i = 0; i < 11; i++)
      send_byte(b[i], (gfix >= 0) ? gfix : $urandom_range(gmax, 0));
    if (!nowait) wait_reply();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, base;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    frame(8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 0, 2, -1, 0);
    rd_respond = 1; rd_lat = 3; rd_word = 32'h1234_5678;
    frame(8'h02, 32'h0000_0010, 32'h0, 0, 2, -1, 0);
    rd_respond = 0;
    frame(8'h02, 32'h0000_0024, 32'h0, 0, 2, -1, 0);
    rd_respond = 1; rd_lat = 0; rd_word = 32'hCAFE_F00D;
    frame(8'h02, 32'h0000_0100, 32'h0, 0, 1, -1, 0);
    rd_lat = RDM - 1; rd_word = 32'h0BAD_CAFE;
    frame(8'h02, 32'h0000_0200, 32'h0, 0, 1, -1, 0);
    processor_paused = 1;
    frame(8'h04, 32'h8000_0000, 32'h0, 0, 2, -1, 0);
    processor_paused = 0;
    frame(8'h04, 32'h8000_0000, 32'h0, 0, 2, -1, 0);
    frame(8'h01, 32'h0000_0044, 32'h1111_2222, 1, 2, -1, 0);
    frame(8'h05, 32'h0, 32'h0000_0005, 0, 0, -1, 0);
    frame(8'h7F, 32'h1234_0000, 32'h7777_8888, 0, 2, -1, 0);
    frame(8'h03, 32'h0000_001F, 32'h5A5A_5A5A, 0, 0, -1, 0);
    send_noise(6);
    frame(8'h03, 32'h0000_0007, 32'hA5A5_0001, 0, 1, -1, 0);
    frame(8'h01, 32'h0000_BEEF, 32'h0102_0304, 0, 0, BT - 5, 0);

    // Partial frame then silence: discarded, next frame starts clean
    send_byte(8'h5A, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1); send_byte(8'h00, 1);
    repeat (BT + 20) @(negedge clk);
    frame(8'h01, 32'h0000_0020, 32'h5555_AAAA, 0, 2, -1, 0);

    // sync_reset mid-frame clears state and outputs
    send_byte(8'h5A, 1); send_byte(8'h03, 1); send_byte(8'h00, 1);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    outs_zero("sync_reset");
    repeat (20) @(negedge clk);
    frame(8'h03, 32'h0000_0003, 32'h3333_3333, 0, 2, -1, 0);

    // reset_n mid-reply aborts the reply
    base = tx_seen;
    frame(8'h01, 32'h0000_0030, 32'h9999_0000, 0, 1, -1, 1);
    n = 0;
    while (tx_seen < base + 2 && n < 2000) begin @(negedge clk); n++; end
    check("send_started", {63'h0, n >= 2000}, 64'h0);
    reset_n = 1'b0;
    #1;
    outs_zero("async_reset");
    exp_q.delete(); ev_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    frame(8'h01, 32'h0000_0034, 32'h4242_4242, 0, 2, -1, 0);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      logic [7:0] cmd;
      int sel;
      sel = $urandom_range(9, 0);
      case (sel)
        0, 1: cmd = 8'h01;
        2, 3: cmd = 8'h02;
        4:    cmd = 8'h03;
        5:    cmd = 8'h04;
        6:    cmd = 8'h05;
        7:    cmd = 8'h7F;
        default: cmd = 8'($urandom);
      endcase
      processor_paused = 1'($urandom_range(1, 0));
      rd_respond = ($urandom_range(9, 0) != 0);
      rd_lat     = $urandom_range(RDM - 1, 0);
      rd_word    = $urandom;
      send_noise($urandom_range(2, 0));
      frame(cmd, $urandom, $urandom, ($urandom_range(6, 0) == 0), 3, -1, 0);
    end

    repeat (20) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'h0);
    check("ev_q_empty", 64'(ev_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
